// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised bit-pattern detector.
// SEQDET_MASK_EN adds per-bit don't-care masking of the pattern.
package seq_det_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        ARMED
    } seq_state_e;

    localparam int SD_PAT_W = 4;
    localparam int SD_LEN_W = $clog2(SD_PAT_W + 1);

    function automatic int unsigned clamp_len(
        input int unsigned len,
        input int unsigned max_len
    );
        if (len == 0 || len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Stream, configuration and result bundle of the pattern detector.
// SEQDET_MASK_EN adds the cfg_mask field.
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             din;
    logic             din_vld;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             clr_cnt;
`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0] cfg_mask;
`endif
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
`ifdef SEQDET_MASK_EN
        output cfg_mask,
`endif
        output din, din_vld, cfg_we,
        output cfg_pat, cfg_len, cfg_ovl,
        output clr_cnt,
        input  match, match_cnt, cnt_sat
    );

    modport slave (
`ifdef SEQDET_MASK_EN
        input  cfg_mask,
`endif
        input  din, din_vld, cfg_we,
        input  cfg_pat, cfg_len, cfg_ovl,
        input  clr_cnt,
        output match, match_cnt, cnt_sat
    );

endinterface

// File: rtl/seq_det_cnt.sv
// Saturating hit counter with synchronous clear and sticky saturation flag.
module seq_det_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_i) begin
            // A hit on the clearing edge is the first count of the new window
            cnt_d = inc_i ? CNT_W'(1) : '0;
            sat_d = 1'b0;
        end else if (inc_i) begin
            if (cnt_q == MAX) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                sat_d = (cnt_q == MAX - CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with saturating hit count.
// SEQDET_MASK_EN enables don't-care bits in the compared pattern.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1011)
) (
    input logic                clk,
    input logic                rst_n,
    seq_detector_param_if.slave bus
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             match_q;
`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;
`endif

    logic [PAT_W-1:0] shift;
    logic [PAT_W-1:0] care;
    logic [LEN_W:0]   fill_p1;
    logic [LEN_W:0]   len_x;
    logic             armed;
    logic             hit;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
`ifdef SEQDET_MASK_EN
        mask_d  = mask_q;
`endif
        hit     = 1'b0;
        shift   = {hist_q[PAT_W-2:0], bus.din};
        fill_p1 = {1'b0, fill_q} + (LEN_W+1)'(1);
        len_x   = {1'b0, len_q};
        for (int i = 0; i < PAT_W; i++) begin
            care[i] = (i < int'(len_q));
        end
`ifdef SEQDET_MASK_EN
        care = care & ~mask_q;
`endif
        // With len=1 every valid bit can complete a hit, even from EMPTY
        armed = (state_q == ARMED) || (len_q == LEN_W'(1));

        if (bus.cfg_we) begin
            pat_d   = bus.cfg_pat;
            len_d   = LEN_W'(clamp_len(int'(bus.cfg_len), PAT_W));
            ovl_d   = bus.cfg_ovl;
`ifdef SEQDET_MASK_EN
            mask_d  = bus.cfg_mask;
`endif
            hist_d  = '0;
            fill_d  = '0;
            state_d = EMPTY;
        end else if (bus.din_vld) begin
            hist_d = shift;
            hit    = armed && (((shift ^ pat_q) & care) == '0);
            if (hit && !ovl_q) begin
                fill_d = '0;
            end else if (fill_p1 > len_x) begin
                fill_d = len_q;
            end else begin
                fill_d = fill_p1[LEN_W-1:0];
            end
            if (fill_d == '0) begin
                state_d = EMPTY;
            end else if ({1'b0, fill_d} + (LEN_W+1)'(1) >= len_x) begin
                state_d = ARMED;
            end else begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            fill_q  <= '0;
            hist_q  <= '0;
            pat_q   <= RST_PAT;
            len_q   <= LEN_MAX;
            ovl_q   <= 1'b0;
            match_q <= 1'b0;
`ifdef SEQDET_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            match_q <= hit;
`ifdef SEQDET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    logic [CNT_W-1:0] cnt;
    logic             sat;

    seq_det_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.clr_cnt),
        .inc_i (hit),
        .cnt_o (cnt),
        .sat_o (sat)
    );

    assign bus.match     = match_q;
    assign bus.match_cnt = cnt;
    assign bus.cnt_sat   = sat;

endmodule
